pll_reset_seq: RTL



---
 rtl/pll_reset_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// Reset sequencer and lock supervisor for the board PLLs. It resets the PLL, qualifies lock,
// retries on lock timeout, then releases the per-domain resets one at a time in a fixed order.
module pll_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int PLL_RST_CYC = 16,
  parameter int TIMEOUT_CYC = 65536,
  parameter int STABLE_CYC  = 1024,
  parameter int STAGE_GAP   = 64,
  parameter int N_DOM       = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             pll_locked,
  output logic             pll_areset,
  output logic [N_DOM-1:0] dom_srst,
  output logic             all_ready,
  output logic [7:0]       relock_cnt,
  output logic [7:0]       timeout_cnt
);

  localparam int MAX_AB  = (PLL_RST_CYC > TIMEOUT_CYC) ? PLL_RST_CYC : TIMEOUT_CYC;
  localparam int MAX_CD  = (STABLE_CYC > STAGE_GAP) ? STABLE_CYC : STAGE_GAP;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(N_DOM) + 1;

  localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_areset_q, pll_areset_d;
  logic [N_DOM-1:0]       dom_srst_q, dom_srst_d;
  logic                   all_ready_q, all_ready_d;
  logic [7:0]             relock_cnt_q, relock_cnt_d;
  logic [7:0]             timeout_cnt_q, timeout_cnt_d;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    sync_d        = {sync_q[SYNC_STAGES-2:0], pll_locked};
    pll_areset_d  = pll_areset_q;
    dom_srst_d    = dom_srst_q;
    all_ready_d   = all_ready_q;
    relock_cnt_d  = relock_cnt_q;
    timeout_cnt_d = timeout_cnt_q;

    case (state_q)
      PLL_RST: begin
        pll_areset_d = 1'b1;
        if (timer_q == RST_LAST) begin
          state_d      = WAIT_LOCK;
          timer_d      = '0;
          pll_areset_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_LOCK: begin
        // A lock seen on the expiry cycle takes priority over the timeout.
        if (lock_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
          state_d      = PLL_RST;
          timer_d      = '0;
          pll_areset_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RELEASE;
          timer_d = '0;
          idx_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        if (timer_q == GAP_LAST) begin
          for (int k = 0; k < N_DOM; k++) begin
            if (int'(idx_q) == k) dom_srst_d[k] = 1'b0;
          end
          timer_d = '0;
          idx_d   = idx_q + IW'(1);
          if (int'(idx_q) == N_DOM - 1) begin
            all_ready_d = 1'b1;
            state_d     = RUN;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = PLL_RST;
        timer_d = '0;
      end
    endcase

    // Lock loss once release has begun drops every domain at once; the PLL itself is left alone.
    if (!lock_s && (state_q == RELEASE || state_q == RUN)) begin
      dom_srst_d  = '1;
      all_ready_d = 1'b0;
      if (relock_cnt_q != 8'hFF) relock_cnt_d = relock_cnt_q + 8'd1;
      state_d     = WAIT_LOCK;
      timer_d     = '0;
      idx_d       = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= PLL_RST;
      timer_q       <= '0;
      idx_q         <= '0;
      sync_q        <= '0;
      pll_areset_q  <= 1'b1;
      dom_srst_q    <= '1;
      all_ready_q   <= 1'b0;
      relock_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      sync_q        <= sync_d;
      pll_areset_q  <= pll_areset_d;
      dom_srst_q    <= dom_srst_d;
      all_ready_q   <= all_ready_d;
      relock_cnt_q  <= relock_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign pll_areset  = pll_areset_q;
  assign dom_srst    = dom_srst_q;
  assign all_ready   = all_ready_q;
  assign relock_cnt  = relock_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
